writeback_arbiter: RTL and testbench

- Write-back front end for `banco_registradores`: drives its `RegWrite`/`WriteReg`/`WriteData` port, the write side of the register file.
- Accepts results from two producers, the ALU and the memory-load path, over valid/ready handshakes.
- Buffers accepted results in a small FIFO and retires one write per cycle.
- Publishes a per-register pending mask so issue logic can stall on read-after-write hazards.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/writeback_arbiter.sv | 125 ++++++++++++
 tb/tb_writeback_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file write-back arbiter.
// Holds the entry layout, default widths and the source-id encoding.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] idx;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue: circular storage with read/write pointers and occupancy.
// Ports: clock, Resetn (async low), push/wdata, pop/rdata, full, empty.
module wb_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             Resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_W'(1);
            if (do_pop)
                rptr <= rptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back front end: arbitrates ALU/load results into a FIFO, retires one
// register-file write per cycle and publishes a per-register pending mask.
// Ports: clock, Resetn; Alu{Valid,Reg,Data,Ready}; Mem{Valid,Reg,Data,Ready};
// RegWrite/WriteReg/WriteData to the register file; Busy pending mask.
// Option: define WB_RR_EN for round-robin priority on contended cycles.
import wb_pkg::*;

module writeback_arbiter #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                 clock,
    input  logic                 Resetn,
    input  logic                 AluValid,
    input  logic [ADDR_W-1:0]    AluReg,
    input  logic [DATA_W-1:0]    AluData,
    output logic                 AluReady,
    input  logic                 MemValid,
    input  logic [ADDR_W-1:0]    MemReg,
    input  logic [DATA_W-1:0]    MemData,
    output logic                 MemReady,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    WriteReg,
    output logic [DATA_W-1:0]    WriteData,
    output logic [2**ADDR_W-1:0] Busy
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PW    = $clog2(DEPTH + 2);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic              full;
    logic              empty;
    logic              cand;
    logic              mem_first;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_reg;
    logic [DATA_W-1:0] push_data;
    logic [ENT_W-1:0]  head;
    logic [PW-1:0]     pend [NREG];

    // Ready depends on registered occupancy only, never on this cycle's pop.
    assign cand = Resetn && !full;

`ifdef WB_RR_EN
    wb_src_e last_grant;

    // Reset to ALU so the first contended grant goes to Mem.
    assign mem_first = (last_grant == SRC_ALU);

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn)
            last_grant <= SRC_ALU;
        else if (cand && AluValid && MemValid)
            last_grant <= MemReady ? SRC_MEM : SRC_ALU;
    end
`else
    assign mem_first = 1'b1;
`endif

    always_comb begin
        MemReady = cand && MemValid && (mem_first || !AluValid);
        AluReady = cand && AluValid && !(MemValid && mem_first);
    end

    assign push      = MemReady || AluReady;
    assign push_reg  = MemReady ? MemReg : AluReg;
    assign push_data = MemReady ? MemData : AluData;
    assign pop       = !empty;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .Resetn(Resetn),
        .push  (push),
        .wdata ({push_reg, push_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Output stage: index/data hold their last values while idle.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                WriteReg  <= head[ENT_W-1:DATA_W];
                WriteData <= head[DATA_W-1:0];
            end
        end
    end

    // A register stays pending until the cycle its write is on the port ends.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int r = 0; r < NREG; r++)
                pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (push && push_reg == ADDR_W'(r)
                    && !(RegWrite && WriteReg == ADDR_W'(r)))
                    pend[r] <= pend[r] + PW'(1);
                else if (RegWrite && WriteReg == ADDR_W'(r)
                    && !(push && push_reg == ADDR_W'(r)))
                    pend[r] <= pend[r] - PW'(1);
            end
        end
    end

    always_comb begin
        Busy = '0;
        for (int r = 0; r < NREG; r++)
            Busy[r] = (pend[r] != '0);
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: scoreboard of accepted writes,
// register-file model and per-scenario directed tasks.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic        clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        AluValid = 1'b0;
    logic [2:0]  AluReg = '0;
    logic [15:0] AluData = '0;
    logic        AluReady;
    logic        MemValid = 1'b0;
    logic [2:0]  MemReg = '0;
    logic [15:0] MemData = '0;
    logic        MemReady;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic [7:0]  Busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    wb_entry_t sb[$];
    logic [15:0] rf [8];
    byte gnt;

    writeback_arbiter dut (
        .clock    (clock),
        .Resetn   (Resetn),
        .AluValid (AluValid),
        .AluReg   (AluReg),
        .AluData  (AluData),
        .AluReady (AluReady),
        .MemValid (MemValid),
        .MemReg   (MemReg),
        .MemData  (MemData),
        .MemReady (MemReady),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .Busy     (Busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (Resetn && RegWrite === 1'b1)
            rf[WriteReg] <= WriteData;

    // Every retired write must match the oldest accepted one.
    always @(negedge clock) begin
        wb_entry_t e;
        if (Resetn && RegWrite === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL retire_extra: got r%0d=%h, none queued",
                         WriteReg, WriteData);
            end else begin
                e = sb.pop_front();
                if ({WriteReg, WriteData} !== e)
                    $display("FAIL retire_order: got r%0d=%h want r%0d=%h",
                             WriteReg, WriteData, e.idx, e.data);
                else
                    pass_cnt++;
            end
        end
    end

    // Drive one cycle of offers at the negedge and log what is accepted.
    task automatic drive(input logic av, input logic [2:0] ar,
                         input logic [15:0] ad, input logic mv,
                         input logic [2:0] mr, input logic [15:0] md);
        @(negedge clock);
        AluValid = av; AluReg = ar; AluData = ad;
        MemValid = mv; MemReg = mr; MemData = md;
        #1;
        gnt = "-";
        if (MemValid && MemReady) begin
            sb.push_back('{idx: MemReg, data: MemData});
            gnt = "M";
        end
        if (AluValid && AluReady) begin
            sb.push_back('{idx: AluReg, data: AluData});
            gnt = (gnt == "M") ? "X" : "A";
        end
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        AluValid = 1'b0;
        MemValid = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL drain_timeout: %0d left, want 0", sb.size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clock);
        AluValid = 1'b1; MemValid = 1'b1;
        #1;
        total_cnt++;
        if ({RegWrite, WriteReg, WriteData, Busy, AluReady, MemReady} !== '0)
            $display("FAIL reset_state: got %b/%h/%h/%h/%b%b want all 0",
                     RegWrite, WriteReg, WriteData, Busy, AluReady, MemReady);
        else
            pass_cnt++;
        AluValid = 1'b0; MemValid = 1'b0;
        @(negedge clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 3'(i + 1), 16'(16'h00A0 + i), 1'b0, 3'd0, 16'h0);
        @(negedge clock);
        #2 Resetn = 1'b0;
        #1;
        total_cnt++;
        if ({RegWrite, WriteReg, WriteData, Busy, AluReady, MemReady} !== '0)
            $display("FAIL reset_mid: got %b/%h/%h/%h/%b%b want all 0",
                     RegWrite, WriteReg, WriteData, Busy, AluReady, MemReady);
        else
            pass_cnt++;
        sb.delete();
        AluValid = 1'b0;
        @(negedge clock);
        Resetn = 1'b1;
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        @(negedge clock);
        AluValid = 1'b0;
        total_cnt++;
        if (RegWrite !== 1'b0)
            $display("FAIL reset_first_early: RegWrite=%b want 0", RegWrite);
        else
            pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 3'd3, 16'h1234})
            $display("FAIL reset_first_write: got %b r%0d=%h want 1 r3=1234",
                     RegWrite, WriteReg, WriteData);
        else
            pass_cnt++;
        drain();
    endtask

    task automatic test_single();
        int wr = 0;
        int bz = 0;
        drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        total_cnt++;
        if (gnt !== "A")
            $display("FAIL single_accept: grant=%c want A", gnt);
        else
            pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            AluValid = 1'b0;
            if (RegWrite && WriteReg == 3'd5 && WriteData == 16'hBEEF)
                wr++;
            if (Busy[5])
                bz++;
        end
        total_cnt++;
        if (wr != 1)
            $display("FAIL single_write_cycles: got %0d want 1", wr);
        else
            pass_cnt++;
        total_cnt++;
        if (bz != 2)
            $display("FAIL single_busy_cycles: got %0d want 2", bz);
        else
            pass_cnt++;
        drain();
    endtask

    task automatic test_contention();
        string order = "";
        string want;
        logic [15:0] md = 16'h0001;
        logic [15:0] ad = 16'h0002;
`ifdef WB_RR_EN
        want = "MAMA";
`else
        want = "MMMM";
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd2, ad, 1'b1, 3'd1, md);
            order = {order, string'(gnt)};
            if (gnt == "M") md++;
            if (gnt == "A") ad++;
        end
        total_cnt++;
        if (order != want)
            $display("FAIL contention_order: got %s want %s", order, want);
        else
            pass_cnt++;
        idle_inputs();
        drain();
    endtask

    task automatic test_full();
        int rdy = 0;
        int acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 16'(16'h0C00 + i), 1'b0, 3'd0, 16'h0);
            if (AluReady) rdy++;
        end
        total_cnt++;
        if (rdy != 4)
            $display("FAIL full_ready_b2b: got %0d want 4", rdy);
        else
            pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0)
                drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(i + 3), 16'(16'h0D00 + i));
            else
                drive(1'b1, 3'(i + 3), 16'(16'h0E00 + i), 1'b0, 3'd0, 16'h0);
            if (gnt == "M" || gnt == "A") acc++;
        end
        total_cnt++;
        if (acc != 5)
            $display("FAIL full_accept5: got %0d want 5", acc);
        else
            pass_cnt++;
        idle_inputs();
        drain();
    endtask

    task automatic test_same_reg();
        int bz = 0;
        drive(1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 16'h0);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h2222);
        if (Busy[4]) bz++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            MemValid = 1'b0;
            if (Busy[4]) bz++;
        end
        total_cnt++;
        if (bz != 3)
            $display("FAIL same_reg_busy: got %0d want 3", bz);
        else
            pass_cnt++;
        drain();
        total_cnt++;
        if (rf[4] !== 16'h2222)
            $display("FAIL same_reg_final: got %h want 2222", rf[4]);
        else
            pass_cnt++;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            #1;
            if (RegWrite !== 1'b0 || Busy !== 8'h00 ||
                AluReady !== 1'b0 || MemReady !== 1'b0)
                bad++;
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL idle_quiet: got %0d bad cycles want 0", bad);
        else
            pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            rf[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_same_reg();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
